// File: rtl/hazard_sched_ctrl.sv
// Hazard controller: load-use stall, branch flush, EX forwarding,
// MDU wait sequencing with timeout and saturating perf counters.
module hazard_sched_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             LoadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MduStartE,
  input  logic             MduDone,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MduTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int BW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [BW-1:0] busy;
  logic          lw_stall;

  assign lw_stall = LoadE && (RdE != 5'd0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reset) begin
      if (RegWriteM && Rs1E != 5'd0 && Rs1E == RdM)
        ForwardAE = 2'b10;
      else if (RegWriteW && Rs1E != 5'd0 && Rs1E == RdW)
        ForwardAE = 2'b01;
      if (RegWriteM && Rs2E != 5'd0 && Rs2E == RdM)
        ForwardBE = 2'b10;
      else if (RegWriteW && Rs2E != 5'd0 && Rs2E == RdW)
        ForwardBE = 2'b01;
    end
  end

  // Stall/flush depend only on registered state and EX/ID inputs,
  // never on MduDone, so release is always one cycle after done.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (MduStartE) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
          end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE;
          end
        end
        BUSY: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= '0;
      MduTimeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MduStartE) begin
            state <= BUSY;
            busy  <= BW'(1);
          end
        end
        BUSY: begin
          if (MduDone) begin
            state <= DONE;
          end else if (busy == BW'(TIMEOUT)) begin
            state      <= IDLE;
            MduTimeout <= 1'b1;
          end else begin
            busy <= busy + BW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && StallCnt != '1)
        StallCnt <= StallCnt + 1'b1;
      if (FlushD && FlushCnt != '1)
        FlushCnt <= FlushCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Bench for hazard_sched_ctrl: per-cycle model compare plus
// directed scenarios with hand-computed expectations.
module tb_hazard_sched_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0;
  logic [4:0]    RdE = 0, RdM = 0, RdW = 0;
  logic          LoadE = 0, RegWriteM = 0, RegWriteW = 0;
  logic          PCSrcE = 0, MduStartE = 0, MduDone = 0;
  logic          StallF, StallD, StallE;
  logic          FlushD, FlushE, FlushM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          MduTimeout;
  logic [CW-1:0] StallCnt, FlushCnt;

  int checks = 0;
  int errors = 0;

  hazard_sched_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MduStartE(MduStartE), .MduDone(MduDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MduTimeout(MduTimeout),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: which cycle of an MDU wait we are in (0 = none),
  // whether the one-cycle drain follows, and the counter totals.
  int m_busy = 0;
  bit m_done = 0;
  bit m_tmo  = 0;
  int m_sc   = 0;
  int m_fc   = 0;

  function automatic logic [5:0] exp_ctl();
    logic lw;
    lw = LoadE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    if (!reset || m_done) return 6'b000000;
    if (m_busy > 0 || MduStartE) return 6'b111001;
    return {lw, lw, 1'b0, PCSrcE, lw | PCSrcE, 1'b0};
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] rs);
    if (!reset || rs == 0) return 2'b00;
    if (RegWriteM && rs == RdM) return 2'b10;
    if (RegWriteW && rs == RdW) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [5:0] e;
    if (!reset) begin
      m_busy = 0;
      m_done = 0;
      m_tmo  = 0;
      m_sc   = 0;
      m_fc   = 0;
    end else begin
      e = exp_ctl();
      if (e[5] && m_sc < MAXC) m_sc++;
      if (e[2] && m_fc < MAXC) m_fc++;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy > 0) begin
        if (MduDone) begin
          m_busy = 0;
          m_done = 1;
        end else if (m_busy == TO) begin
          m_busy = 0;
          m_tmo  = 1;
        end else begin
          m_busy++;
        end
      end else if (MduStartE) begin
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    e = exp_ctl();
    chk("ctl", {StallF, StallD, StallE, FlushD, FlushE, FlushM}, e);
    chk("fwdA", ForwardAE, exp_fwd(Rs1E));
    chk("fwdB", ForwardBE, exp_fwd(Rs2E));
    chk("tmo", MduTimeout, m_tmo);
    chk("scnt", StallCnt, m_sc);
    chk("fcnt", FlushCnt, m_fc);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mdu_run(input int start_last, input int done_at,
                         input int n, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      MduStartE = (i <= start_last);
      MduDone   = (i == done_at);
      @(negedge clk);
      if (StallE) stalls++;
      nxt();
    end
    MduStartE = 0;
    MduDone   = 0;
  endtask

  int st;

  initial begin
    nxt();
    nxt();
    @(negedge clk);
    chk("rst_stall", StallF, 1'b0);
    chk("rst_cnt", StallCnt, 4'd0);
    reset = 1'b1;
    nxt();

    LoadE = 1; RdE = 5; Rs1D = 5;
    @(negedge clk);
    chk("lu_stall", {StallF, StallD, FlushE}, 3'b111);
    nxt();
    RdE = 0; Rs1D = 0;
    @(negedge clk);
    chk("lu_rd0", StallF, 1'b0);
    nxt();
    LoadE = 0;
    @(negedge clk);
    chk("lu_cnt", StallCnt, 4'd1);

    RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3;
    Rs1E = 3; Rs2E = 3;
    #1 chk("fw_mem", ForwardAE, 2'b10);
    RegWriteM = 0;
    #1 chk("fw_wb", ForwardAE, 2'b01);
    Rs1E = 0;
    #1 chk("fw_x0", ForwardAE, 2'b00);
    chk("fw_b_wb", ForwardBE, 2'b01);
    nxt();
    RegWriteW = 0; Rs2E = 0;

    PCSrcE = 1;
    @(negedge clk);
    chk("br_flush", {FlushD, FlushE, StallF}, 3'b110);
    nxt();
    PCSrcE = 0;
    @(negedge clk);
    chk("br_cnt", FlushCnt, 4'd1);
    nxt();

    MduDone = 1;
    nxt();
    MduDone = 0;

    mdu_run(6, 5, 10, st);
    chk("mdu_stalls", st, 6);
    @(negedge clk);
    chk("mdu_scnt", StallCnt, 4'd7);
    nxt();

    mdu_run(9, TO, 12, st);
    chk("lim_stalls", st, 9);
    @(negedge clk);
    chk("lim_noflag", MduTimeout, 1'b0);
    chk("sat_cnt", StallCnt, 4'd15);
    nxt();

    mdu_run(TO, -1, 12, st);
    chk("to_stalls", st, 9);
    @(negedge clk);
    chk("to_flag", MduTimeout, 1'b1);
    chk("sat_hold", StallCnt, 4'd15);
    nxt();
    nxt();
    chk("to_sticky", MduTimeout, 1'b1);

    MduStartE = 1;
    nxt();
    nxt();
    nxt();
    #2 reset = 1'b0;
    #1;
    chk("ar_stall", {StallF, StallE, FlushM}, 3'b000);
    chk("ar_tmo", MduTimeout, 1'b0);
    chk("ar_cnt", StallCnt, 4'd0);
    nxt();
    MduStartE = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("ar_idle", StallE, 1'b0);
    nxt();
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
